// File: rtl/processor_pio_pkg.sv
// Shared constants for the processor PIO block: register word addresses and
// edge-capture type selectors.
package processor_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  localparam int unsigned BUS_WIDTH = 32;

endpackage

// File: rtl/processor_pio_sync.sv
// Input synchroniser for the PIO block: a SYNC_STAGES-deep flop chain per bit,
// a one-cycle delayed copy (in_prev) and the selected edge-detect pulse.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous reset, active-low
//   i_in     in   WIDTH asynchronous pad inputs
//   o_sync   out  WIDTH synchronised inputs
//   o_edge   out  WIDTH one-cycle edge pulses of the type chosen by EDGE_TYPE
module processor_pio_sync
  import processor_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= i_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = o_sync & ~r_prev;
  assign w_fall = ~o_sync & r_prev;

  always_comb begin
    o_edge = w_rise;
    if (EDGE_TYPE == EDGE_FALL) begin
      o_edge = w_fall;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      o_edge = w_rise | w_fall;
    end
  end

endmodule

// File: rtl/processor_pio_gen.sv
// Avalon-MM zero-wait-state general-purpose I/O slave with per-bit direction,
// synchronised input sampling, edge capture (write-1-to-clear) and a level IRQ.
// Build option: define PIO_BITSET_EN to enable atomic OUTSET (addr 4) and
// OUTCLR (addr 5) writes; otherwise those addresses read 0 and ignore writes.
//
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   address       3-bit word address; chipselect, write_n: bus controls
//   writedata     32-bit write data (bits above WIDTH ignored)
//   readdata      32-bit combinational read data, zero-extended
//   in_port       WIDTH asynchronous inputs
//   out_port      data_out register; out_oe: direction register (1 = drive)
//   irq           |(edge_cap & irq_mask)
module processor_pio_gen
  import processor_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0,
  parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [BUS_WIDTH-1:0] writedata,
  output logic [BUS_WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0]     in_port,
  output logic [WIDTH-1:0]     out_port,
  output logic [WIDTH-1:0]     out_oe,
  output logic                 irq
);

  logic [WIDTH-1:0]     r_data_out, r_dir, r_mask, r_edge_cap;
  logic [WIDTH-1:0]     w_data_out_d, w_dir_d, w_mask_d, w_edge_cap_d;
  logic [WIDTH-1:0]     w_in_sync, w_edge, w_wd;
  logic [BUS_WIDTH-1:0] w_rd;
  logic                 w_wr;
  logic                 w_unused_wd;

  processor_pio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .i_in   (in_port),
    .o_sync (w_in_sync),
    .o_edge (w_edge)
  );

  assign w_wr        = chipselect & ~write_n;
  assign w_wd        = writedata[WIDTH-1:0];
  assign w_unused_wd = ^writedata;

  always_comb begin
    w_data_out_d = r_data_out;
    w_dir_d      = r_dir;
    w_mask_d     = r_mask;
    w_edge_cap_d = r_edge_cap;
    if (w_wr) begin
      case (address)
        ADDR_DATA:   w_data_out_d = w_wd;
        ADDR_DIR:    w_dir_d      = w_wd;
        ADDR_MASK:   w_mask_d     = w_wd;
        ADDR_EDGE:   w_edge_cap_d = r_edge_cap & ~w_wd;
`ifdef PIO_BITSET_EN
        ADDR_OUTSET: w_data_out_d = r_data_out | w_wd;
        ADDR_OUTCLR: w_data_out_d = r_data_out & ~w_wd;
`endif
        default: ;
      endcase
    end
    // New edges are OR-ed in after the clear so a coincident set wins.
    w_edge_cap_d = w_edge_cap_d | w_edge;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= RESET_VALUE;
      r_dir      <= DIR_RESET;
      r_mask     <= '0;
      r_edge_cap <= '0;
    end else begin
      r_data_out <= w_data_out_d;
      r_dir      <= w_dir_d;
      r_mask     <= w_mask_d;
      r_edge_cap <= w_edge_cap_d;
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      ADDR_DATA: w_rd[WIDTH-1:0] = (w_in_sync & ~r_dir) | (r_data_out & r_dir);
      ADDR_DIR:  w_rd[WIDTH-1:0] = r_dir;
      ADDR_MASK: w_rd[WIDTH-1:0] = r_mask;
      ADDR_EDGE: w_rd[WIDTH-1:0] = r_edge_cap;
      default: ;
    endcase
  end

  assign readdata = w_rd;
  assign out_port = r_data_out;
  assign out_oe   = r_dir;
  assign irq      = |(r_edge_cap & r_mask);

endmodule

// File: tb/tb_processor_pio_gen.sv
// Bench for processor_pio_gen: three instances (rising, falling, any edge)
// share one bus and one input port, checked against a history-based model.
module tb_processor_pio_gen;
  import processor_pio_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned S  = 2;
  localparam logic [7:0]  RV = 8'hA5;
  localparam logic [7:0]  DR = 8'h0F;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [2:0]  address = 3'd0;
  logic [31:0] writedata = 32'd0;
  logic [7:0]  in_port = 8'h00;
  logic [31:0] dut_rd  [3];
  logic [7:0]  dut_op  [3];
  logic [7:0]  dut_oe  [3];
  logic        dut_irq [3];

  int checks = 0;
  int errors = 0;

  // Model state; m_hist[0] is in_port as sampled at the most recent edge.
  logic [7:0] m_dout, m_dir, m_mask;
  logic [7:0] m_ecap [3];
  logic [7:0] m_hist [$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    processor_pio_gen #(
      .WIDTH      (W),
      .RESET_VALUE(RV),
      .DIR_RESET  (DR),
      .EDGE_TYPE  (k),
      .SYNC_STAGES(S)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (dut_rd[k]),
      .in_port   (in_port),
      .out_port  (dut_op[k]),
      .out_oe    (dut_oe[k]),
      .irq       (dut_irq[k])
    );
  end

  task automatic model_reset();
    m_dout = RV;
    m_dir  = DR;
    m_mask = 8'h00;
    for (int k = 0; k < 3; k++) m_ecap[k] = 8'h00;
    m_hist.delete();
    repeat (S + 1) m_hist.push_back(8'h00);
  endtask

  // Applies the current bus/pin inputs as the next clock edge will.
  task automatic model_edge();
    logic [7:0] ins, prev, rise, fall, det, wd;
    logic wr;
    if (!reset_n) return;
    ins  = m_hist[S-1];
    prev = m_hist[S];
    rise = ins & ~prev;
    fall = ~ins & prev;
    wd   = writedata[7:0];
    wr   = chipselect && !write_n;
    for (int k = 0; k < 3; k++) begin
      det = (k == 0) ? rise : (k == 1) ? fall : (rise | fall);
      if (wr && address == ADDR_EDGE) m_ecap[k] = m_ecap[k] & ~wd;
      m_ecap[k] = m_ecap[k] | det;
    end
    if (wr) begin
      case (address)
        ADDR_DATA: m_dout = wd;
        ADDR_DIR:  m_dir  = wd;
        ADDR_MASK: m_mask = wd;
`ifdef PIO_BITSET_EN
        ADDR_OUTSET: m_dout = m_dout | wd;
        ADDR_OUTCLR: m_dout = m_dout & ~wd;
`endif
        default: ;
      endcase
    end
    m_hist.push_front(in_port);
    void'(m_hist.pop_back());
  endtask

  function automatic logic [31:0] exp_read(int k);
    logic [31:0] r;
    r = 32'd0;
    case (address)
      ADDR_DATA: r[7:0] = (m_hist[S-1] & ~m_dir) | (m_dout & m_dir);
      ADDR_DIR:  r[7:0] = m_dir;
      ADDR_MASK: r[7:0] = m_mask;
      ADDR_EDGE: r[7:0] = m_ecap[k];
      default: ;
    endcase
    return r;
  endfunction

  task automatic tick();
    model_edge();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read_setup(input logic [2:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_read_setup(ADDR_EDGE);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut_op[k] !== 8'hA5) begin
        errors++; $display("FAIL reset_out_port[%0d] got %h want a5", k, dut_op[k]);
      end
      checks++;
      if (dut_oe[k] !== 8'h0F) begin
        errors++; $display("FAIL reset_out_oe[%0d] got %h want 0f", k, dut_oe[k]);
      end
      checks++;
      if (dut_irq[k] !== 1'b0) begin
        errors++; $display("FAIL reset_irq[%0d] got %b want 0", k, dut_irq[k]);
      end
      checks++;
      if (dut_rd[k] !== 32'd0) begin
        errors++; $display("FAIL reset_edge[%0d] got %h want 0", k, dut_rd[k]);
      end
    end
    bus_read_setup(ADDR_DATA);
    checks++;
    if (dut_rd[0] !== 32'h0000_0005) begin
      errors++; $display("FAIL reset_data_read got %h want 00000005", dut_rd[0]);
    end
  endtask

  task automatic test_data_write();
    bus_write(ADDR_DIR, 32'h0000_00FF);
    bus_write(ADDR_DATA, 32'hABCD_EF3C);
    checks++;
    if (dut_op[0] !== 8'h3C) begin
      errors++; $display("FAIL data_out got %h want 3c", dut_op[0]);
    end
    bus_read_setup(ADDR_DATA);
    checks++;
    if (dut_rd[0] !== 32'h0000_003C) begin
      errors++; $display("FAIL data_read got %h want 0000003c", dut_rd[0]);
    end
    // Write strobe without chipselect must be ignored.
    address = ADDR_DATA; writedata = 32'h55; chipselect = 1'b0; write_n = 1'b0;
    tick();
    write_n = 1'b1;
    checks++;
    if (dut_op[0] !== 8'h3C) begin
      errors++; $display("FAIL no_cs_write got %h want 3c", dut_op[0]);
    end
  endtask

  task automatic test_edge_latency();
    logic [7:0] exp_e [3];
    exp_e = '{8'h01, 8'h00, 8'h01};
    bus_write(ADDR_DIR, 32'h0);
    bus_write(ADDR_MASK, 32'h1);
    bus_read_setup(ADDR_DATA);
    in_port = 8'h01;
    for (int i = 1; i <= 3; i++) begin
      tick();
      #1;
      checks++;
      if (dut_irq[0] !== (i == 3)) begin
        errors++; $display("FAIL irq_latency cyc%0d got %b want %b", i, dut_irq[0], i == 3);
      end
      if (i < 3) begin
        checks++;
        if (dut_rd[0] !== ((i == 2) ? 32'h1 : 32'h0)) begin
          errors++; $display("FAIL data_latency cyc%0d got %h want %h", i, dut_rd[0], i == 2);
        end
      end
    end
    bus_read_setup(ADDR_EDGE);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut_rd[k] !== {24'h0, exp_e[k]}) begin
        errors++; $display("FAIL edge_after_rise[%0d] got %h want %h", k, dut_rd[k], exp_e[k]);
      end
    end
    bus_write(ADDR_EDGE, 32'h1);
    checks++;
    if (dut_irq[0] !== 1'b0) begin
      errors++; $display("FAIL irq_after_w1c got %b want 0", dut_irq[0]);
    end
  endtask

  task automatic test_w1c_collision();
    bus_write(ADDR_MASK, 32'h4);
    in_port = 8'h05;
    tick();
    tick();
    bus_write(ADDR_EDGE, 32'h4);
    bus_read_setup(ADDR_EDGE);
    checks++;
    if (dut_rd[0] !== 32'h4) begin
      errors++; $display("FAIL collision_edge got %h want 00000004", dut_rd[0]);
    end
    checks++;
    if (dut_irq[0] !== 1'b1) begin
      errors++; $display("FAIL collision_irq got %b want 1", dut_irq[0]);
    end
    bus_write(ADDR_EDGE, 32'hFF);
    checks++;
    if (dut_irq[0] !== 1'b0) begin
      errors++; $display("FAIL collision_clear_irq got %b want 0", dut_irq[0]);
    end
  endtask

  task automatic test_edge_types();
    logic [7:0] exp_r [3];
    logic [7:0] exp_f [3];
    exp_r = '{8'h01, 8'h00, 8'h01};
    exp_f = '{8'h01, 8'h01, 8'h01};
    in_port = 8'h00;
    repeat (4) tick();
    bus_write(ADDR_EDGE, 32'hFF);
    in_port = 8'h01;
    repeat (4) tick();
    bus_read_setup(ADDR_EDGE);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut_rd[k] !== {24'h0, exp_r[k]}) begin
        errors++; $display("FAIL type_rise[%0d] got %h want %h", k, dut_rd[k], exp_r[k]);
      end
    end
    in_port = 8'h00;
    repeat (4) tick();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut_rd[k] !== {24'h0, exp_f[k]}) begin
        errors++; $display("FAIL type_fall[%0d] got %h want %h", k, dut_rd[k], exp_f[k]);
      end
    end
    bus_write(ADDR_EDGE, 32'hFF);
  endtask

  task automatic test_bitset();
    logic [7:0] want;
`ifdef PIO_BITSET_EN
    want = 8'h71;
`else
    want = 8'hF0;
`endif
    bus_write(ADDR_DIR, 32'hFF);
    bus_write(ADDR_DATA, 32'hF0);
    bus_write(ADDR_OUTSET, 32'h01);
    bus_write(ADDR_OUTCLR, 32'h80);
    checks++;
    if (dut_op[0] !== want) begin
      errors++; $display("FAIL bitset_out got %h want %h", dut_op[0], want);
    end
    for (int a = 4; a < 8; a++) begin
      bus_read_setup(3'(a));
      checks++;
      if (dut_rd[0] !== 32'd0) begin
        errors++; $display("FAIL read_addr%0d got %h want 0", a, dut_rd[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus_write(ADDR_MASK, 32'hFF);
    bus_write(ADDR_DATA, 32'h5A);
    in_port = 8'h00;
    repeat (4) tick();
    in_port = 8'hFF;
    repeat (4) tick();
    #1;
    checks++;
    if (dut_irq[0] !== 1'b1) begin
      errors++; $display("FAIL pre_reset_irq got %b want 1", dut_irq[0]);
    end
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut_op[k] !== 8'hA5 || dut_oe[k] !== 8'h0F || dut_irq[k] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset[%0d] got op=%h oe=%h irq=%b want a5 0f 0", k, dut_op[k],
                 dut_oe[k], dut_irq[k]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dut_op[k] !== m_dout || dut_oe[k] !== m_dir) begin
          errors++;
          $display("FAIL rand_regs[%0d] n=%0d got op=%h oe=%h want %h %h", k, n, dut_op[k],
                   dut_oe[k], m_dout, m_dir);
        end
        checks++;
        if (dut_irq[k] !== |(m_ecap[k] & m_mask)) begin
          errors++; $display("FAIL rand_irq[%0d] n=%0d got %b want %b", k, n, dut_irq[k],
                             |(m_ecap[k] & m_mask));
        end
        if (chipselect) begin
          checks++;
          if (dut_rd[k] !== exp_read(k)) begin
            errors++; $display("FAIL rand_read[%0d] n=%0d addr=%0d got %h want %h", k, n,
                               address, dut_rd[k], exp_read(k));
          end
        end
      end
      if ($urandom_range(0, 2) == 0) in_port = 8'($urandom);
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) != 0);
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_edge_latency();
    test_w1c_collision();
    test_edge_types();
    test_bitset();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
